// File: rtl/banco_pkg.sv
// Shared constants and state encoding for the register bank and its read ports.
package banco_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } estado_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

endpackage

// File: rtl/banco_registros_if.sv
// Bus bundle of the register bank: packed read ports, one write port and status.
interface banco_registros_if #(
  parameter int DATA_W = banco_pkg::DEF_DATA_W,
  parameter int ADDR_W = banco_pkg::DEF_ADDR_W,
  parameter int NREAD  = banco_pkg::DEF_NREAD
) ();

  logic [NREAD*ADDR_W-1:0] ARead;
  logic [NREAD*DATA_W-1:0] DRead;
  logic [ADDR_W-1:0]       AWR;
  logic [DATA_W-1:0]       DataIn;
  logic                    WE;
  logic                    Ready;
  logic                    WrDrop;

  modport master (
    output ARead, AWR, DataIn, WE,
    input  DRead, Ready, WrDrop
  );

  modport slave (
    input  ARead, AWR, DataIn, WE,
    output DRead, Ready, WrDrop
  );

endinterface

// File: rtl/banco_registros_puerto_lectura.sv
// One read port: blanks data outside RUN, pins address 0 to zero and forwards
// a same-cycle write when bypass is enabled.
module puerto_lectura
  import banco_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic              en_lectura,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dato_mem,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] dato
);

  always_comb begin
    dato = '0;
    if (en_lectura) begin
      // Address 0 is checked first so a write to it is never forwarded.
      if ((ZERO_REG != 0) && (addr == '0)) begin
        dato = '0;
      end else if ((BYPASS != 0) && wr_en && (addr == wr_addr)) begin
        dato = wr_data;
      end else begin
        dato = dato_mem;
      end
    end
  end

endmodule

// File: rtl/banco_registros.sv
// Multi-port register file that zero-fills itself after reset (CLEAR) before
// accepting writes (RUN). Reads are combinational.
module banco_registros
  import banco_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input logic              clk,
  input logic              rst,
  banco_registros_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ULTIMA = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              wrdrop_q, wrdrop_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              zero_hit;
  logic              en_lectura;
  logic              wr_bypass;

  assign zero_hit = (ZERO_REG != 0) && (bus.AWR == '0);

  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    ready_d  = ready_q;
    wrdrop_d = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = bus.AWR;
    mem_wd   = bus.DataIn;
    case (estado_q)
      CLEAR: begin
        // The clear pointer owns the single write path until the last address.
        mem_we   = 1'b1;
        mem_wa   = ptr_q;
        mem_wd   = '0;
        wrdrop_d = bus.WE;
        if (ptr_q == ULTIMA) begin
          estado_d = RUN;
          ready_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        mem_we = bus.WE && !zero_hit;
      end
      default: begin
        estado_d = CLEAR;
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= CLEAR;
      ptr_q    <= '0;
      ready_q  <= 1'b0;
      wrdrop_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ptr_q    <= ptr_d;
      ready_q  <= ready_d;
      wrdrop_q <= wrdrop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign en_lectura = (estado_q == RUN) && !rst;
  assign wr_bypass  = en_lectura && bus.WE;

  logic [DATA_W-1:0] dato_w [NREAD];

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_lectura
    logic [ADDR_W-1:0] addr_i;
    assign addr_i = bus.ARead[gi*ADDR_W +: ADDR_W];

    puerto_lectura #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_puerto (
      .en_lectura (en_lectura),
      .addr       (addr_i),
      .dato_mem   (mem_q[addr_i]),
      .wr_en      (wr_bypass),
      .wr_addr    (bus.AWR),
      .wr_data    (bus.DataIn),
      .dato       (dato_w[gi])
    );
  end

  always_comb begin
    bus.DRead = '0;
    for (int i = 0; i < NREAD; i++) begin
      bus.DRead[i*DATA_W +: DATA_W] = dato_w[i];
    end
  end

  assign bus.Ready  = ready_q;
  assign bus.WrDrop = wrdrop_q;

endmodule

// File: tb/tb_banco_registros.sv
// Bench for banco_registros: bypass and non-bypass 32-bit banks plus a small
// 4-port 8-bit bank, checked against a scoreboard of expected read data.
module tb_banco_registros;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banco_registros_if bus0 ();
  banco_registros_if bus1 ();
  banco_registros_if #(.DATA_W(8), .ADDR_W(3), .NREAD(4)) bus2 ();

  banco_registros #(.BYPASS(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  banco_registros #(.BYPASS(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  banco_registros #(.DATA_W(8), .ADDR_W(3), .NREAD(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } esperado_t;

  esperado_t   sb_q [$];
  logic [31:0] modelo0 [32];
  logic [7:0]  modelo2 [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    esperado_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    esperado_t e;
    if (sb_q.size() == 0) begin
      e.tag = "sb_underflow";
      e.exp = 'x;
    end else begin
      e = sb_q.pop_front();
    end
    check_val(e.tag, obs, e.exp);
  endtask

  function automatic logic [31:0] leer_modelo(input logic [4:0] ar, input logic we,
                                              input logic [4:0] aw, input logic [31:0] d,
                                              input bit bypass);
    if (ar == 5'd0) return 32'd0;
    if (bypass && we && (ar == aw)) return d;
    return modelo0[ar];
  endfunction

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  // Same write to both 32-bit banks, committed at the next edge.
  task automatic escribir(input logic [4:0] aw, input logic [31:0] d);
    bus0.WE = 1'b1; bus0.AWR = aw; bus0.DataIn = d;
    bus1.WE = 1'b1; bus1.AWR = aw; bus1.DataIn = d;
    ciclo();
    bus0.WE = 1'b0;
    bus1.WE = 1'b0;
    if (aw != 5'd0) modelo0[aw] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) modelo0[i] = 32'd0;
    for (int i = 0; i < 8; i++) modelo2[i] = 8'd0;
    bus0.ARead = {5'd0, 5'd3}; bus0.AWR = 5'd3; bus0.DataIn = 32'hAAAA5555; bus0.WE = 1'b1;
    bus1.ARead = {5'd0, 5'd3}; bus1.AWR = 5'd3; bus1.DataIn = 32'hAAAA5555; bus1.WE = 1'b1;
    bus2.ARead = '0; bus2.AWR = 3'd2; bus2.DataIn = 8'h77; bus2.WE = 1'b1;

    // Reset held: writes ignored, no drop pulse, reads zero.
    repeat (3) ciclo();
    check_val("rst_ready0",  32'(bus0.Ready), 32'd0);
    check_val("rst_wrdrop0", 32'(bus0.WrDrop), 32'd0);
    check_val("rst_dread0",  bus0.DRead[31:0], 32'd0);
    check_val("rst_ready2",  32'(bus2.Ready), 32'd0);
    check_val("rst_wrdrop2", 32'(bus2.WrDrop), 32'd0);
    bus2.WE = 1'b0;

    #2 rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      ciclo();
      check_val($sformatf("clr_ready0_e%0d", k), 32'(bus0.Ready), 32'(k == 32));
      check_val($sformatf("clr_wrdrop0_e%0d", k), 32'(bus0.WrDrop), 32'd1);
      if (k <= 10) check_val($sformatf("clr_ready2_e%0d", k), 32'(bus2.Ready), 32'(k >= 8));
      if (k == 16) check_val("clr_dread0_mid", bus0.DRead[31:0], 32'd0);
    end
    bus0.WE = 1'b0;
    bus1.WE = 1'b0;
    check_val("run_wrdrop2", 32'(bus2.WrDrop), 32'd0);
    #1;
    sb_push("clr_reg3", 32'd0);
    sb_pop(bus0.DRead[31:0]);
    ciclo();
    check_val("run_wrdrop0", 32'(bus0.WrDrop), 32'd0);

    // Write then read the same register on both ports.
    escribir(5'd7, 32'hDEADBEEF);
    bus0.ARead = {5'd7, 5'd7};
    bus1.ARead = {5'd7, 5'd7};
    #1;
    sb_push("r7_p0", modelo0[7]); sb_push("r7_p1", modelo0[7]);
    sb_push("r7_p0_nb", modelo0[7]); sb_push("r7_p1_nb", modelo0[7]);
    sb_pop(bus0.DRead[31:0]); sb_pop(bus0.DRead[63:32]);
    sb_pop(bus1.DRead[31:0]); sb_pop(bus1.DRead[63:32]);

    // Same-cycle write/read of register 9: forwarded only with bypass.
    bus0.WE = 1'b1; bus0.AWR = 5'd9; bus0.DataIn = 32'h12345678; bus0.ARead = {5'd7, 5'd9};
    bus1.WE = 1'b1; bus1.AWR = 5'd9; bus1.DataIn = 32'h12345678; bus1.ARead = {5'd7, 5'd9};
    #1;
    sb_push("byp_p0", 32'h12345678); sb_push("byp_p1", 32'hDEADBEEF);
    sb_push("nobyp_p0", 32'd0);
    sb_pop(bus0.DRead[31:0]); sb_pop(bus0.DRead[63:32]);
    sb_pop(bus1.DRead[31:0]);
    ciclo();
    bus0.WE = 1'b0; bus1.WE = 1'b0;
    modelo0[9] = 32'h12345678;
    #1;
    sb_push("nobyp_after", 32'h12345678);
    sb_pop(bus1.DRead[31:0]);

    // Writes to register 0 are dropped silently.
    bus0.WE = 1'b1; bus0.AWR = 5'd0; bus0.DataIn = 32'hFFFFFFFF; bus0.ARead = {5'd0, 5'd0};
    #1;
    sb_push("z_same", 32'd0);
    sb_pop(bus0.DRead[31:0]);
    ciclo();
    bus0.WE = 1'b0;
    #1;
    check_val("z_wrdrop", 32'(bus0.WrDrop), 32'd0);
    sb_push("z_after", 32'd0);
    sb_pop(bus0.DRead[63:32]);

    // Mixed traffic on both 32-bit banks.
    for (int t = 0; t < 24; t++) begin
      logic        we;
      logic [4:0]  aw, ar0, ar1;
      logic [31:0] d;
      we  = 1'($urandom_range(0, 1));
      aw  = 5'($urandom_range(0, 31));
      d   = $urandom;
      ar0 = (t % 3 == 0) ? aw : 5'($urandom_range(0, 31));
      ar1 = 5'($urandom_range(0, 31));
      bus0.WE = we; bus0.AWR = aw; bus0.DataIn = d; bus0.ARead = {ar1, ar0};
      bus1.WE = we; bus1.AWR = aw; bus1.DataIn = d; bus1.ARead = {ar1, ar0};
      #1;
      sb_push($sformatf("mix%0d_b_p0", t), leer_modelo(ar0, we, aw, d, 1'b1));
      sb_push($sformatf("mix%0d_b_p1", t), leer_modelo(ar1, we, aw, d, 1'b1));
      sb_push($sformatf("mix%0d_n_p0", t), leer_modelo(ar0, we, aw, d, 1'b0));
      sb_pop(bus0.DRead[31:0]); sb_pop(bus0.DRead[63:32]); sb_pop(bus1.DRead[31:0]);
      ciclo();
      if (we && aw != 5'd0) modelo0[aw] = d;
    end
    bus0.WE = 1'b0; bus1.WE = 1'b0;

    // Small bank: fill 0..7 and read four distinct addresses per cycle.
    for (int i = 0; i < 8; i++) begin
      bus2.WE = 1'b1; bus2.AWR = 3'(i); bus2.DataIn = 8'(i * 8'h11);
      ciclo();
      if (i != 0) modelo2[i] = 8'(i * 8'h11);
    end
    bus2.WE = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int j = 0; j < 4; j++) bus2.ARead[j*3 +: 3] = 3'((c + j * 2) % 8);
      #1;
      for (int j = 0; j < 4; j++)
        sb_push($sformatf("q4_c%0d_p%0d", c, j), 32'(modelo2[(c + j * 2) % 8]));
      for (int j = 0; j < 4; j++) sb_pop(32'(bus2.DRead[j*8 +: 8]));
      ciclo();
    end

    // Reset pulse in RUN wipes register 5 and restarts the clear sequence.
    escribir(5'd5, 32'h55);
    bus0.ARead = {5'd0, 5'd5};
    bus2.ARead = 12'(3);
    #1;
    sb_push("r5_before", 32'h55);
    sb_pop(bus0.DRead[31:0]);
    #1 rst = 1'b1;
    #1;
    check_val("rst2_ready0", 32'(bus0.Ready), 32'd0);
    check_val("rst2_ready2", 32'(bus2.Ready), 32'd0);
    check_val("rst2_dread0", bus0.DRead[31:0], 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) modelo0[i] = 32'd0;
    for (int i = 0; i < 8; i++) modelo2[i] = 8'd0;
    for (int k = 1; k <= 32; k++) begin
      ciclo();
      check_val($sformatf("reclr_ready0_e%0d", k), 32'(bus0.Ready), 32'(k == 32));
      if (k <= 10) check_val($sformatf("reclr_ready2_e%0d", k), 32'(bus2.Ready), 32'(k >= 8));
      if (k == 32) check_val("reclr_wrdrop0", 32'(bus0.WrDrop), 32'd0);
    end
    #1;
    sb_push("r5_after", modelo0[5]);
    sb_push("q4_r3_after", 32'(modelo2[3]));
    sb_pop(bus0.DRead[31:0]);
    sb_pop(32'(bus2.DRead[7:0]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
